// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-index width and default statistics counter width.
package pipeline_ctrl_pkg;

  localparam int REG_W         = 5;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LUSTALL = 2'd1,
    ST_BRFLUSH = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use hazard comparator: flags when the load in EX writes a register
// that the instruction in ID reads. Register 0 never creates a hazard.
module hazard_cmp
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] IDrs,
  input  logic [REG_W-1:0] IDrt,
  input  logic             IDUsesRt,
  input  logic             EXMemToReg,
  input  logic             EXRegWrite,
  input  logic [REG_W-1:0] EXDest,
  output logic             LoadUse
);

  // Pure compare; no state.
  assign LoadUse = EXMemToReg && EXRegWrite && (EXDest != '0) &&
                   ((EXDest == IDrs) || (IDUsesRt && (EXDest == IDrt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory
// wait handling with a sticky memory-timeout flag.
// Optional feature: define PIPELINE_HAZARD_STATS_EN to add the StallCount and
// FlushCount saturating statistics outputs.
//
// Memory handshake: MemReq high means the MEM stage is accessing data memory;
// the access completes in the cycle MemReady is high. MemReq && !MemReady
// freezes the front of the pipe; once in MEMWAIT only MemReady is looked at.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [REG_W-1:0] IDrs,
  input  logic [REG_W-1:0] IDrt,
  input  logic             IDUsesRt,
  input  logic             EXMemToReg,
  input  logic             EXRegWrite,
  input  logic [REG_W-1:0] EXDest,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCEnable,
  output logic             IFIDDevEnable,
  output logic             IDEXDevEnable,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             MemTimeout,
  output logic [1:0]       State
`ifdef PIPELINE_HAZARD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // A zero-width counter or zero timeout has no meaningful hardware.
  if (CNT_WIDTH < 1 || MEM_TIMEOUT < 1) begin : g_param_check
  end

  state_t            cur_state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_wait;
  logic              pc_en, ifid_en, idex_en, bubble, flush;

  hazard_cmp u_hazard_cmp (
    .IDrs       (IDrs),
    .IDrt       (IDrt),
    .IDUsesRt   (IDUsesRt),
    .EXMemToReg (EXMemToReg),
    .EXRegWrite (EXRegWrite),
    .EXDest     (EXDest),
    .LoadUse    (load_use)
  );

  assign mem_wait = MemReq && !MemReady;

  // Output decode and next state; stalls act in the cycle they are detected.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    state_nxt = ST_RUN;
    if (!Reset) begin
      if (cur_state == ST_MEMWAIT) begin
        if (!MemReady) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          state_nxt = ST_MEMWAIT;
        end
      end else if (mem_wait) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        state_nxt = ST_MEMWAIT;
      end else if (BranchTaken) begin
        // Branch wins over load-use: the hazarding instruction is squashed.
        bubble    = 1'b1;
        flush     = 1'b1;
        state_nxt = ST_BRFLUSH;
      end else if (load_use && (cur_state == ST_RUN)) begin
        // Only from RUN, so a single load yields exactly one bubble.
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        bubble    = 1'b1;
        state_nxt = ST_LUSTALL;
      end
    end
  end

  // FSM state, consecutive-wait counter and sticky timeout flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cur_state  <= ST_RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      cur_state <= state_nxt;
      if ((cur_state == ST_MEMWAIT) && !MemReady) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_LAST) MemTimeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign PCEnable      = pc_en;
  assign IFIDDevEnable = ifid_en;
  assign IDEXDevEnable = idex_en;
  assign IDEXBubble    = bubble;
  assign IFIDFlush     = flush;
  assign State         = cur_state;

`ifdef PIPELINE_HAZARD_STATS_EN
  // Saturating counts of PC-stall cycles and IF/ID flush cycles.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!pc_en && (StallCount != '1)) StallCount <= StallCount + CNT_WIDTH'(1);
      if (flush && (FlushCount != '1)) FlushCount <= FlushCount + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// constant expectations plus a randomized run against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic       Clock;
  logic       Reset;
  logic [4:0] IDrs, IDrt, EXDest;
  logic       IDUsesRt, EXMemToReg, EXRegWrite, BranchTaken, MemReq, MemReady;
  logic       PCEnable, IFIDDevEnable, IDEXDevEnable, IDEXBubble, IFIDFlush;
  logic       MemTimeout;
  logic [1:0] State;
`ifdef PIPELINE_HAZARD_STATS_EN
  logic [15:0] StallCount, FlushCount;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // {PCEnable, IFIDDevEnable, IDEXDevEnable, IDEXBubble, IFIDFlush}
  wire [4:0] outs = {PCEnable, IFIDDevEnable, IDEXDevEnable, IDEXBubble, IFIDFlush};

  pipeline_hazard_ctrl #(.CNT_WIDTH(16), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .IDrs          (IDrs),
    .IDrt          (IDrt),
    .IDUsesRt      (IDUsesRt),
    .EXMemToReg    (EXMemToReg),
    .EXRegWrite    (EXRegWrite),
    .EXDest        (EXDest),
    .BranchTaken   (BranchTaken),
    .MemReq        (MemReq),
    .MemReady      (MemReady),
    .PCEnable      (PCEnable),
    .IFIDDevEnable (IFIDDevEnable),
    .IDEXDevEnable (IDEXDevEnable),
    .IDEXBubble    (IDEXBubble),
    .IFIDFlush     (IFIDFlush),
    .MemTimeout    (MemTimeout),
    .State         (State)
`ifdef PIPELINE_HAZARD_STATS_EN
    ,
    .StallCount    (StallCount),
    .FlushCount    (FlushCount)
`endif
  );

  // Clock and overall time limit
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (rule level) ----------------
  bit m_waiting;   // a memory access is outstanding
  bit m_suppress;  // previous cycle already bubbled or flushed
  bit m_to;
  int m_wcnt;
  int m_state;     // state number the rules say should be reported
  int m_stall, m_flush;

  function automatic bit m_lu();
    return EXMemToReg && EXRegWrite && (EXDest != 0) &&
           ((EXDest == IDrs) || (IDUsesRt && (EXDest == IDrt)));
  endfunction

  function automatic logic [4:0] m_outs();
    if (m_waiting) return MemReady ? 5'b11100 : 5'b00000;
    if (MemReq && !MemReady) return 5'b00000;
    if (BranchTaken) return 5'b11111;
    if (m_lu() && !m_suppress) return 5'b00110;
    return 5'b11100;
  endfunction

  task automatic m_reset();
    m_waiting = 0; m_suppress = 0; m_to = 0; m_wcnt = 0; m_state = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic m_step(input logic [4:0] o);
    if (!o[4]) m_stall++;
    if (o[0]) m_flush++;
    if (m_waiting) begin
      if (MemReady) begin
        m_waiting = 0; m_wcnt = 0; m_suppress = 0; m_state = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt >= TB_TIMEOUT) m_to = 1;
      end
    end else if (MemReq && !MemReady) begin
      m_waiting = 1; m_wcnt = 0; m_state = 3;
    end else if (BranchTaken) begin
      m_suppress = 1; m_state = 2;
    end else if (m_lu() && !m_suppress) begin
      m_suppress = 1; m_state = 1;
    end else begin
      m_suppress = 0; m_state = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    IDrs = 0; IDrt = 0; IDUsesRt = 0; EXMemToReg = 0; EXRegWrite = 0;
    EXDest = 0; BranchTaken = 0; MemReq = 0; MemReady = 0;
  endtask

  task automatic drive_load(input logic [4:0] dest, input logic [4:0] rs,
                            input logic [4:0] rt, input logic uses_rt);
    EXMemToReg = 1; EXRegWrite = 1; EXDest = dest;
    IDrs = rs; IDrt = rt; IDUsesRt = uses_rt;
  endtask

  // advance one rising edge, land 1 time unit after it
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1; #2; Reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1;
    MemReq = 1; MemReady = 0; drive_load(5'd8, 5'd8, 5'd0, 1'b0); BranchTaken = 1;
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL reset_outs got=%b want=11100", outs); end
    vectors++;
    if (State !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d want=0", State); end
    vectors++;
    if (MemTimeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b want=0", MemTimeout); end
`ifdef PIPELINE_HAZARD_STATS_EN
    vectors++;
    if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      miscompares++; $display("FAIL reset_stats got=%0d/%0d want=0/0", StallCount, FlushCount);
    end
`endif
    tick();
    set_idle();
    Reset = 0;
    tick();
  endtask

  task automatic test_load_use();
    drive_load(5'd8, 5'd8, 5'd3, 1'b0);
    #1;
    vectors++;
    if (outs !== 5'b00110) begin miscompares++; $display("FAIL lu_stall got=%b want=00110", outs); end
    tick();
    vectors++;
    if (State !== 2'd1) begin miscompares++; $display("FAIL lu_state got=%0d want=1", State); end
    #1;
    vectors++;  // hazard still present but must not bubble again
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL lu_once got=%b want=11100", outs); end
    tick();
    vectors++;
    if (State !== 2'd0) begin miscompares++; $display("FAIL lu_back_run got=%0d want=0", State); end
    set_idle();
    tick();
    // rt path only counts when the instruction reads rt
    drive_load(5'd9, 5'd1, 5'd9, 1'b0);
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL lu_rt_unused got=%b want=11100", outs); end
    IDUsesRt = 1;
    #1;
    vectors++;
    if (outs !== 5'b00110) begin miscompares++; $display("FAIL lu_rt_used got=%b want=00110", outs); end
    set_idle();
    tick();
  endtask

  task automatic test_zero_reg();
    drive_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL r0_outs got=%b want=11100", outs); end
    tick();
    vectors++;
    if (State !== 2'd0) begin miscompares++; $display("FAIL r0_state got=%0d want=0", State); end
    set_idle();
  endtask

  task automatic test_branch_load();
    drive_load(5'd8, 5'd8, 5'd0, 1'b0);
    BranchTaken = 1;
    #1;
    vectors++;
    if (outs !== 5'b11111) begin miscompares++; $display("FAIL br_lu_outs got=%b want=11111", outs); end
    tick();
    vectors++;
    if (State !== 2'd2) begin miscompares++; $display("FAIL br_state got=%0d want=2", State); end
    BranchTaken = 0;
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL br_suppress got=%b want=11100", outs); end
    tick();
    vectors++;
    if (State !== 2'd0) begin miscompares++; $display("FAIL br_back_run got=%0d want=0", State); end
    set_idle();
    tick();
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    MemReq = 1; MemReady = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (outs !== 5'b00000) begin miscompares++; $display("FAIL mw_stall%0d got=%b want=00000", c, outs); end
      tick();
      vectors++;
      if (State !== 2'd3) begin miscompares++; $display("FAIL mw_state%0d got=%0d want=3", c, State); end
    end
    MemReady = 1;
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL mw_release got=%b want=11100", outs); end
    tick();
    vectors++;
    if (State !== 2'd0) begin miscompares++; $display("FAIL mw_exit got=%0d want=0", State); end
    vectors++;
    if (MemTimeout !== 1'b0) begin miscompares++; $display("FAIL mw_no_timeout got=%b want=0", MemTimeout); end
`ifdef PIPELINE_HAZARD_STATS_EN
    vectors++;
    if (StallCount !== 16'd3) begin miscompares++; $display("FAIL mw_stallcount got=%0d want=3", StallCount); end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_timeout();
    pulse_reset();
    MemReq = 1; MemReady = 0;
    tick();  // now in MEMWAIT
    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      tick();
      vectors++;
      if (MemTimeout !== (c >= TB_TIMEOUT)) begin
        miscompares++; $display("FAIL to_flag_c%0d got=%b want=%b", c, MemTimeout, (c >= TB_TIMEOUT));
      end
      vectors++;
      if (State !== 2'd3) begin miscompares++; $display("FAIL to_state_c%0d got=%0d want=3", c, State); end
    end
    MemReady = 1;
    tick();
    set_idle();
    tick();
    vectors++;
    if (MemTimeout !== 1'b1 || State !== 2'd0) begin
      miscompares++; $display("FAIL to_sticky got=%b/%0d want=1/0", MemTimeout, State);
    end
  endtask

  task automatic test_reset_mid();
    MemReq = 1; MemReady = 0;
    repeat (TB_TIMEOUT + 2) tick();
    Reset = 1;
    #1;
    vectors++;
    if (State !== 2'd0 || MemTimeout !== 1'b0 || outs !== 5'b11100) begin
      miscompares++; $display("FAIL rst_mid got=st%0d to%b o%b want=st0 to0 o11100", State, MemTimeout, outs);
    end
`ifdef PIPELINE_HAZARD_STATS_EN
    vectors++;
    if (StallCount !== 16'd0) begin miscompares++; $display("FAIL rst_mid_stats got=%0d want=0", StallCount); end
`endif
    tick();
    Reset = 0;
    set_idle();
    #1;
    vectors++;
    if (outs !== 5'b11100) begin miscompares++; $display("FAIL rst_residual got=%b want=11100", outs); end
    tick();
    vectors++;
    if (State !== 2'd0 || outs !== 5'b11100) begin
      miscompares++; $display("FAIL rst_after got=st%0d o%b want=st0 o11100", State, outs);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_o;
    pulse_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      IDrs        = 5'($urandom_range(0, 3));
      IDrt        = 5'($urandom_range(0, 3));
      EXDest      = 5'($urandom_range(0, 3));
      IDUsesRt    = 1'($urandom_range(0, 1));
      EXMemToReg  = ($urandom_range(0, 3) != 0);
      EXRegWrite  = ($urandom_range(0, 3) != 0);
      BranchTaken = ($urandom_range(0, 7) == 0);
      MemReq      = ($urandom_range(0, 5) == 0);
      MemReady    = ($urandom_range(0, 2) == 0);
      #1;
      exp_o = m_outs();
      vectors++;
      if (outs !== exp_o) begin miscompares++; $display("FAIL rnd_outs n=%0d got=%b want=%b", n, outs, exp_o); end
      m_step(exp_o);
      tick();
      vectors++;
      if (State !== 2'(m_state)) begin miscompares++; $display("FAIL rnd_state n=%0d got=%0d want=%0d", n, State, m_state); end
      vectors++;
      if (MemTimeout !== m_to) begin miscompares++; $display("FAIL rnd_timeout n=%0d got=%b want=%b", n, MemTimeout, m_to); end
`ifdef PIPELINE_HAZARD_STATS_EN
      vectors++;
      if (StallCount !== 16'(m_stall) || FlushCount !== 16'(m_flush)) begin
        miscompares++;
        $display("FAIL rnd_stats n=%0d got=%0d/%0d want=%0d/%0d", n, StallCount, FlushCount, m_stall, m_flush);
      end
`endif
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    Reset = 1;
    #2;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_load();
    test_mem_wait();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
